iterative_divider: RTL and testbench

- Multi-cycle RV32M divide/remainder unit in the EX stage; executes DIV, DIVU, REM and REMU.
- Takes SrcAE/SrcBE as dividend/divisor.
- Holds the pipeline via `stall` while iterating.
- Presents the final 32-bit result for capture by the EX/MEM register on the cycle `stall` drops.
- Radix-2 restoring algorithm, one quotient bit per cycle; special cases resolved without iterating.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/div_step.sv | 30 +++
 rtl/iterative_divider.sv | 134 +++++++++++++
 tb/tb_iterative_divider.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide units.
package muldiv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    SPECIAL = 2'd2,
    DONE    = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // rem < divisor on entry, so the trial difference always fits in XLEN+1 bits.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {1'b0, divisor};
    if (trial[XLEN]) begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit for the EX stage; holds the pipeline
// via stall while iterating one quotient bit per cycle.
module iterative_divider
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_is_div,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t state, state_next;

  logic [2:0]       f3_q;
  logic [XLEN-1:0]  dividend;
  logic [XLEN-1:0]  divisor;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  quo;
  logic [CNT_W-1:0] count;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic [XLEN-1:0]  rem_next;
  logic [XLEN-1:0]  quo_next;

  logic             start_signed;
  logic             b_zero;
  logic             overflow;
  logic             is_rem;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign start_signed = (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign b_zero       = (b == '0);
  assign overflow     = start_signed && (a == MIN_NEG) && (b == '1);
  assign is_rem       = (f3_q == F3_REM) || (f3_q == F3_REMU);

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ex_is_div) state_next = (b_zero || overflow) ? SPECIAL : BUSY;
      BUSY:    if (count == '0) state_next = DONE;
      SPECIAL: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = ex_is_div;
      BUSY:    stall = 1'b1;
      SPECIAL: stall = 1'b1;
      DONE:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Operands are captured once in IDLE; later changes on a/b/funct3 are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q     <= '0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_is_div) begin
            f3_q     <= funct3;
            dividend <= a;
            divisor  <= mag(b, start_signed);
            rem      <= '0;
            quo      <= mag(a, start_signed);
            count    <= CNT_W'(XLEN-1);
            neg_q    <= start_signed && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r    <= start_signed && a[XLEN-1];
            div_zero <= b_zero;
          end
        end
        SPECIAL: begin
          if (div_zero) result <= is_rem ? dividend : '1;
          else          result <= is_rem ? '0 : MIN_NEG;
        end
        BUSY: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count - 1'b1;
          // Sign fixup folds into the last iteration so DONE only presents the value.
          if (count == '0)
            result <= is_rem ? cond_neg(rem_next, neg_r) : cond_neg(quo_next, neg_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed corner cases plus random
// operations compared with a plain-arithmetic RV32M reference.
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_is_div;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_res;

  iterative_divider #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .ex_is_div (ex_is_div),
    .funct3    (funct3),
    .a         (a),
    .b         (b),
    .stall     (stall),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    longint unsigned ux;
    longint unsigned uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    case (f3)
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return 32'(sx / sy);
      end
      3'b101: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return 32'(ux / uy);
      end
      3'b110: begin
        if (y == 0) return x;
        return 32'(sx % sy);
      end
      default: begin
        if (y == 0) return x;
        return 32'(ux % uy);
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    return (y == 0) || (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // Starts a divide right after the next rising edge and follows it to DONE.
  task automatic do_div(input string tag, input logic [2:0] f3, input logic [31:0] av,
                        input logic [31:0] bv, input bit scramble);
    logic [31:0] exp;
    int n;
    exp = ref_div(f3, av, bv);
    @(posedge clk); #1;
    ex_is_div = 1'b1;
    funct3    = f3;
    a         = av;
    b         = bv;
    n = 0;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      if (n == 2) begin
        check_val({tag, "_hold"}, result, prev_res);
        if (scramble) begin
          a      = $urandom;
          b      = $urandom;
          funct3 = 3'b100 | 3'($urandom_range(0, 3));
        end
      end
      @(negedge clk);
    end
    check_val({tag, "_stall_cycles"}, 32'(n), is_special(f3, av, bv) ? 32'd2 : 32'd33);
    check_val(tag, result, exp);
    prev_res = exp;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      ex_is_div = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    ex_is_div = 1'b0;
    funct3    = 3'b100;
    a         = '0;
    b         = '0;
    prev_res  = '0;
    repeat (2) @(negedge clk);
    check_val("reset_stall", 32'(stall), 32'd0);
    check_val("reset_result", result, 32'd0);
    reset = 1'b0;

    do_div("div_100_7",   3'b100, 32'd100, 32'd7, 1'b0);
    idle_cycles(1);
    do_div("rem_m100_7",  3'b110, 32'hFFFF_FF9C, 32'd7, 1'b0);
    idle_cycles(1);
    do_div("div_m100_7",  3'b100, 32'hFFFF_FF9C, 32'd7, 1'b0);
    idle_cycles(1);
    do_div("divu_max_2",  3'b101, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle_cycles(1);
    do_div("remu_max_2",  3'b111, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle_cycles(1);
    do_div("div_by0",     3'b100, 32'h1234_5678, 32'd0, 1'b0);
    idle_cycles(1);
    do_div("divu_by0",    3'b101, 32'h1234_5678, 32'd0, 1'b0);
    idle_cycles(1);
    do_div("rem_by0",     3'b110, 32'h1234_5678, 32'd0, 1'b1);
    idle_cycles(1);
    do_div("remu_by0",    3'b111, 32'h1234_5678, 32'd0, 1'b0);
    idle_cycles(1);
    do_div("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle_cycles(1);
    do_div("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle_cycles(1);
    do_div("divu_minneg", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    // Back-to-back: second divide starts the cycle after the first DONE.
    idle_cycles(1);
    do_div("b2b_divu",    3'b101, 32'd10, 32'd3, 1'b0);
    do_div("b2b_remu",    3'b111, 32'd10, 32'd3, 1'b1);

    // Reset in the middle of a third divide.
    @(posedge clk); #1;
    ex_is_div = 1'b1;
    funct3    = 3'b100;
    a         = 32'd1000;
    b         = 32'd3;
    repeat (11) @(negedge clk);
    check_val("mid_busy_stall", 32'(stall), 32'd1);
    reset     = 1'b1;
    ex_is_div = 1'b0;
    #1;
    check_val("abort_stall", 32'(stall), 32'd0);
    check_val("abort_result", result, 32'd0);
    @(negedge clk);
    check_val("abort_idle_stall", 32'(stall), 32'd0);
    reset    = 1'b0;
    prev_res = '0;
    do_div("after_abort", 3'b110, 32'd1000, 32'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] av;
      logic [31:0] bv;
      int sel;
      f3  = 3'b100 | 3'($urandom_range(0, 3));
      av  = $urandom;
      bv  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) bv = '0;
      else if (sel == 1) begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
      else if (sel < 5) bv = 32'($urandom_range(1, 300)) ^ {32{bv[31]}};
      do_div($sformatf("rnd%0d", i), f3, av, bv, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end

    idle_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
